credit_rx_fifo: RTL and testbench
=================================

// Module: credit_rx_fifo
// PURPOSE
//  Credit-based receive endpoint for metro-mpi links, parametrised in data width and buffer depth.
//  Accepts words from a valid/yummy credit link and stores them in a DEPTH-entry circular FIFO.
//  Presents stored words first-word-fall-through on a valid/ready interface.
//  Returns one yummy (credit) per word consumed and flags credit-protocol violations.
// PARAMETERS
//  DATA_W  64  payload width in bits
//  DEPTH   4   FIFO entries = credits granted to the sender at reset; legal range 1..256, not restricted to powers of 2
//  CNT_W   $clog2(DEPTH+1)  localparam; width of occupancy and free-slot counters
// PORTS
//  clk_i         in   1       clock, all state updates on posedge
//  rstn_i        in   1       asynchronous active-low reset
//  valid_i       in   1       link word present this cycle
//  data_i        in   DATA_W  link payload, sampled when valid_i=1
//  yummy_o       out  1       credit return, one pulse per word popped
//  valid_o       out  1       FIFO head valid
//  data_o        out  DATA_W  FIFO head word
//  ready_i       in   1       consumer accepts head this cycle
//  count_o       out  CNT_W   current occupancy, 0..DEPTH
//  free_o        out  CNT_W   DEPTH - count_o
//  overflow_o    out  1       sticky: a word arrived while the FIFO was full
//  clear_err_i   in   1       synchronous clear of overflow_o
// BEHAVIOUR
//  Reset (async assert, sync-to-clk deassert by the system):
//   - wr_ptr = rd_ptr = count = 0.
//   - yummy_o = 0, valid_o = 0, data_o = 0, overflow_o = 0, free_o = DEPTH.
//   - Storage array is not reset.
//  Push = valid_i & (count_q < DEPTH):
//   - mem[wr_ptr] <= data_i.
//   - wr_ptr advances, wrapping from DEPTH-1 to 0.
//  Dropped word = valid_i & (count_q == DEPTH):
//   - Word is discarded; pointers and count are unchanged.
//   - overflow_o <= 1 at the same edge.
//   - A pop in the same cycle does NOT make room. Credits lag pops, so a correct sender never sends into a full FIFO.
//  Pop = valid_o & ready_i:
//   - rd_ptr advances, wrapping from DEPTH-1 to 0.
//  Output side:
//   - valid_o = (count_q != 0). data_o = mem[rd_ptr] when valid_o, else 0. Both are combinational from registers.
//   - Latency: a word pushed at edge N is visible on data_o/valid_o after edge N, i.e. in cycle N+1 when the FIFO was empty.
//   - There is no same-cycle bypass from data_i to data_o.
//  Occupancy:
//   - count_d = count_q + push - pop.
//   - Simultaneous push and pop leaves count unchanged and is legal at any occupancy < DEPTH, including 0 (push only, since pop needs valid_o).
//  Credit return:
//   - yummy_o is registered: yummy_o <= pop, so it is high the cycle after each pop.
//   - Back-to-back pops give back-to-back yummy pulses; there is no coalescing.
//   - Invariant: sender credits + count_q + yummy_o == DEPTH at every edge.
//  Error clear:
//   - clear_err_i=1 clears overflow_o next edge.
//   - If a drop occurs in the same cycle as clear_err_i, set wins.
//  Reset mid-operation:
//   - All stored words are discarded and any pending yummy is lost.
//   - The sender shares rstn_i and restores DEPTH credits.
//  Pointer arithmetic is modulo DEPTH using an explicit compare-and-wrap, never bit truncation.
// TESTING
//  - Reset, DEPTH=4: no stimulus -> valid_o=0, data_o=0, count_o=0, free_o=4, yummy_o=0, overflow_o=0.
//  - Single word: push 0xA5 at cycle 1 with ready_i=0 -> valid_o=1 and data_o=0xA5 from cycle 2. Raise ready_i in cycle 3 -> yummy_o=1 in cycle 4 only, count_o back to 0.
//  - Fill and wrap: push 0..3 (FIFO full, free_o=0), pop 2, push 4,5 -> pops return 0,1,2,3,4,5 in order across the wrap. Exactly 6 yummy pulses in total.
//  - Overflow: push 5 words into the DEPTH=4 FIFO with ready_i=0 -> 5th word dropped, overflow_o=1 and stays set. clear_err_i pulse -> overflow_o=0 next cycle.
//  - Streaming, ready_i=1 and valid_i=1 each cycle for 100 cycles -> count_o stays 1, one yummy per cycle after the first pop, data in order, no overflow.
//  - Reset with count_o=3 and yummy_o=1 -> all outputs return to reset values immediately, with no clock edge needed. Run with DEPTH=1 and DEPTH=5 as well.

Source files
------------

// File: rtl/credit_rx_fifo.sv
// Purpose  : credit-based receive endpoint; link words land in a DEPTH-entry FIFO, one yummy returned per pop.
// Latency  : a word pushed at edge N is at the head from cycle N+1 (no data_i->data_o bypass); yummy_o one cycle after the pop.
// Backpres.: the sender is throttled by credits only; a word arriving while full is dropped and flagged in overflow_o.
//
// Ports
//   clk_i        clock, all state updates on posedge
//   rstn_i       asynchronous active-low reset
//   valid_i      link word present this cycle
//   data_i       link payload, sampled when valid_i=1
//   yummy_o      credit return, one pulse per word popped
//   valid_o      FIFO head valid
//   data_o       FIFO head word (zero when empty)
//   ready_i      consumer accepts the head this cycle
//   count_o      current occupancy, 0..DEPTH
//   free_o       DEPTH - count_o
//   overflow_o   sticky: a word arrived while the FIFO was full
//   clear_err_i  synchronous clear of overflow_o (a same-cycle drop wins)

// Generic circular buffer: storage, wrap-around pointers and occupancy.
// Caller guarantees push_i only when not full and pop_i only when not empty.
module credit_rx_fifo_buf #(
    parameter  int DATA_W = 64,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wr_dat_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rd_dat_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              empty_o,
    output logic              full_o
);

    // A single-entry buffer still needs a one-bit pointer to index storage.
    localparam int                PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]  LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // DEPTH need not be a power of two, so wrap by compare rather than
    // letting the pointer overflow its bit width.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == LAST) begin
            n = '0;
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        // Push and pop together leave the occupancy unchanged.
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; stale entries are never visible because
    // the read side is gated by occupancy in the parent.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

    assign rd_dat_o = mem_q[rd_ptr_q];
    assign count_o  = count_q;
    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == FULL);

endmodule

// Receive endpoint: credit-protocol front end around the circular buffer.
module credit_rx_fifo #(
    parameter  int DATA_W = 64,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              yummy_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              ready_i,
    output logic [CNT_W-1:0]  count_o,
    output logic [CNT_W-1:0]  free_o,
    output logic              overflow_o,
    input  logic              clear_err_i
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic              push;
    logic              drop;
    logic              pop;
    logic              buf_empty;
    logic              buf_full;
    logic [DATA_W-1:0] buf_rd_dat;
    logic [CNT_W-1:0]  buf_count;

    logic              yummy_q, yummy_d;
    logic              overflow_q, overflow_d;

    // Fullness is judged on the registered occupancy only: a pop in the
    // same cycle does not open a slot, since its credit has not yet been
    // returned and a well-behaved sender cannot be using it.
    assign push = valid_i & ~buf_full;
    assign drop = valid_i &  buf_full;
    assign pop  = valid_o &  ready_i;

    credit_rx_fifo_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .push_i   (push),
        .wr_dat_i (data_i),
        .pop_i    (pop),
        .rd_dat_o (buf_rd_dat),
        .count_o  (buf_count),
        .empty_o  (buf_empty),
        .full_o   (buf_full)
    );

    always_comb begin
        // One credit per popped word, registered; consecutive pops give
        // consecutive pulses with no merging.
        yummy_d    = pop;
        overflow_d = overflow_q;
        if (clear_err_i) begin
            overflow_d = 1'b0;
        end
        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            yummy_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            yummy_q    <= yummy_d;
            overflow_q <= overflow_d;
        end
    end

    // Head is first-word-fall-through from registered state; the data
    // bus is forced to zero while empty so unreset storage never leaks.
    assign valid_o    = ~buf_empty;
    assign data_o     = valid_o ? buf_rd_dat : '0;
    assign count_o    = buf_count;
    assign free_o     = FULL - buf_count;
    assign yummy_o    = yummy_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_credit_rx_fifo.sv
module tb_credit_rx_fifo;

    localparam int N = 3;

    logic        clk         = 1'b0;
    logic        rstn_i      = 1'b1;
    logic        valid_i     = 1'b0;
    logic        ready_i     = 1'b0;
    logic        clear_err_i = 1'b0;
    logic [63:0] data_i      = '0;

    logic        vo  [N];
    logic        yo  [N];
    logic        ovo [N];
    logic [63:0] dox [N];
    int          cnt_a [N];
    int          fre_a [N];

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    // Reference model: per-instance queue of stored words plus two flags.
    logic [63:0] mq [N][$];
    bit          m_yum [N];
    bit          m_ovf [N];

    logic [63:0] popped [$];
    int          ycnt = 0;

    function automatic int dep(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 1 : 5);
    endfunction

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int D  = (g == 0) ? 4 : ((g == 1) ? 1 : 5);
        localparam int CW = $clog2(D + 1);
        logic [CW-1:0] c;
        logic [CW-1:0] f;
        credit_rx_fifo #(.DATA_W(64), .DEPTH(D)) u_dut (
            .clk_i       (clk),
            .rstn_i      (rstn_i),
            .valid_i     (valid_i),
            .data_i      (data_i),
            .yummy_o     (yo[g]),
            .valid_o     (vo[g]),
            .data_o      (dox[g]),
            .ready_i     (ready_i),
            .count_o     (c),
            .free_o      (f),
            .overflow_o  (ovo[g]),
            .clear_err_i (clear_err_i)
        );
        assign cnt_a[g] = int'(c);
        assign fre_a[g] = int'(f);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mq[i].delete();
            m_yum[i] = 1'b0;
            m_ovf[i] = 1'b0;
        end
    endtask

    // Effect of one clock edge given the inputs held across it.
    task automatic model_edge();
        int sz;
        bit p_pop, p_push, p_drop;
        for (int i = 0; i < N; i++) begin
            sz     = mq[i].size();
            p_pop  = (sz != 0) && ready_i;
            p_push = valid_i && (sz < dep(i));
            p_drop = valid_i && (sz == dep(i));
            if (p_pop)  void'(mq[i].pop_front());
            if (p_push) mq[i].push_back(data_i);
            m_yum[i] = p_pop;
            if (p_drop)           m_ovf[i] = 1'b1;
            else if (clear_err_i) m_ovf[i] = 1'b0;
        end
    endtask

    // Drive inputs for one cycle (called just after a posedge), cross the edge.
    task automatic cyc(input bit v, input logic [63:0] d, input bit r, input bit c);
        valid_i     = v;
        data_i      = d;
        ready_i     = r;
        clear_err_i = c;
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic reset_lits(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_d%0d_valid", tag, dep(i)), 64'(vo[i]), 64'd0);
            check($sformatf("%s_d%0d_data",  tag, dep(i)), dox[i], 64'd0);
            check($sformatf("%s_d%0d_count", tag, dep(i)), 64'(cnt_a[i]), 64'd0);
            check($sformatf("%s_d%0d_yummy", tag, dep(i)), 64'(yo[i]), 64'd0);
            check($sformatf("%s_d%0d_ovf",   tag, dep(i)), 64'(ovo[i]), 64'd0);
        end
        check({tag, "_d4_free"}, 64'(fre_a[0]), 64'd4);
        check({tag, "_d1_free"}, 64'(fre_a[1]), 64'd1);
        check({tag, "_d5_free"}, 64'(fre_a[2]), 64'd5);
    endtask

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        int sz;
        logic [63:0] exp_d;
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                sz    = mq[i].size();
                exp_d = (sz != 0) ? mq[i][0] : 64'd0;
                check($sformatf("m_d%0d_valid", dep(i)), 64'(vo[i]), 64'(sz != 0));
                check($sformatf("m_d%0d_data",  dep(i)), dox[i], exp_d);
                check($sformatf("m_d%0d_count", dep(i)), 64'(cnt_a[i]), 64'(sz));
                check($sformatf("m_d%0d_free",  dep(i)), 64'(fre_a[i]), 64'(dep(i) - sz));
                check($sformatf("m_d%0d_yummy", dep(i)), 64'(yo[i]), 64'(m_yum[i]));
                check($sformatf("m_d%0d_ovf",   dep(i)), 64'(ovo[i]), 64'(m_ovf[i]));
            end
        end
    end

    // Pop and credit monitor for the DEPTH=4 instance.
    always @(negedge clk) begin
        if (rstn_i && vo[0] && ready_i) popped.push_back(dox[0]);
        if (rstn_i && yo[0]) ycnt++;
    end

    initial begin
        model_reset();
        chk_en = 1'b1;
        #1 rstn_i = 1'b0;
        #2;
        reset_lits("rst");
        repeat (2) @(negedge clk);
        #1 rstn_i = 1'b1;
        cyc(0, '0, 0, 0);

        // Single word with delayed consumer.
        cyc(1, 64'hA5, 0, 0);
        check("sw_valid_c2", 64'(vo[0]), 64'd1);
        check("sw_data_c2", dox[0], 64'hA5);
        cyc(0, '0, 0, 0);
        check("sw_valid_c3", 64'(vo[0]), 64'd1);
        check("sw_yummy_c3", 64'(yo[0]), 64'd0);
        cyc(0, '0, 1, 0);
        check("sw_yummy_c4", 64'(yo[0]), 64'd1);
        check("sw_count_c4", 64'(cnt_a[0]), 64'd0);
        cyc(0, '0, 0, 0);
        check("sw_yummy_c5", 64'(yo[0]), 64'd0);

        // Fill, partial drain, refill across the wrap.
        popped.delete();
        ycnt = 0;
        for (int k = 0; k < 4; k++) cyc(1, 64'(k), 0, 0);
        check("fw_count_full", 64'(cnt_a[0]), 64'd4);
        check("fw_free_full", 64'(fre_a[0]), 64'd0);
        repeat (2) cyc(0, '0, 1, 0);
        cyc(1, 64'd4, 0, 0);
        cyc(1, 64'd5, 0, 0);
        repeat (4) cyc(0, '0, 1, 0);
        repeat (2) cyc(0, '0, 0, 0);
        check("fw_pop_count", 64'(popped.size()), 64'd6);
        for (int k = 0; k < 6 && k < popped.size(); k++)
            check($sformatf("fw_pop%0d", k), popped[k], 64'(k));
        check("fw_yummies", 64'(ycnt), 64'd6);

        // Overflow and clear.
        for (int k = 0; k < 5; k++) begin
            cyc(1, 64'(10 + k), 0, 0);
            if (k == 3) check("ov_before_drop", 64'(ovo[0]), 64'd0);
        end
        check("ov_set", 64'(ovo[0]), 64'd1);
        check("ov_count", 64'(cnt_a[0]), 64'd4);
        cyc(0, '0, 0, 0);
        check("ov_sticky", 64'(ovo[0]), 64'd1);
        cyc(0, '0, 0, 1);
        check("ov_cleared", 64'(ovo[0]), 64'd0);
        popped.delete();
        repeat (4) cyc(0, '0, 1, 0);
        cyc(0, '0, 0, 0);
        check("ov_drain_n", 64'(popped.size()), 64'd4);
        for (int k = 0; k < 4 && k < popped.size(); k++)
            check($sformatf("ov_drain%0d", k), popped[k], 64'(10 + k));

        // Streaming at full rate.
        popped.delete();
        ycnt = 0;
        for (int k = 0; k < 100; k++) begin
            cyc(1, 64'(1000 + k), 1, 0);
            check($sformatf("st_count%0d", k), 64'(cnt_a[0]), 64'd1);
        end
        check("st_no_ovf", 64'(ovo[0]), 64'd0);
        cyc(0, '0, 1, 0);
        repeat (2) cyc(0, '0, 0, 0);
        check("st_pop_n", 64'(popped.size()), 64'd100);
        for (int k = 0; k < 100 && k < popped.size(); k++)
            check($sformatf("st_pop%0d", k), popped[k], 64'(1000 + k));
        check("st_yummies", 64'(ycnt), 64'd100);

        // Asynchronous reset with words stored and a credit pending.
        for (int k = 0; k < 4; k++) cyc(1, 64'(50 + k), 0, 0);
        cyc(0, '0, 1, 0);
        check("ar_count_pre", 64'(cnt_a[0]), 64'd3);
        check("ar_yummy_pre", 64'(yo[0]), 64'd1);
        #2 rstn_i = 1'b0;
        #1;
        model_reset();
        reset_lits("arst");
        @(negedge clk);
        #1 rstn_i = 1'b1;
        cyc(0, '0, 0, 0);

        // Randomized traffic, including protocol violations and clears.
        for (int k = 0; k < 800; k++) begin
            cyc($urandom_range(0, 99) < 55, {$urandom, $urandom},
                $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 5);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
